// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter with a rotating one-hot token, grant/done handshake,
// a one-cycle dead gap between owners and a forced release at the hold limit.
module ring_token_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 timeout
);

    localparam int OW = $clog2(N);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_ptr;
    logic [N-1:0]    w_ptr_nxt;
    logic [N-1:0]    r_grant;
    logic [N-1:0]    w_grant_nxt;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   w_owner_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic            r_timeout;
    logic            w_timeout_nxt;

    logic [N-1:0]    w_req_hi;
    logic [N-1:0]    w_pick;
    logic            w_rel_normal;
    logic            w_rel_forced;

    function automatic logic [OW-1:0] onehot_idx(input logic [N-1:0] oh);
        logic [OW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) idx = i[OW-1:0];
        end
        return idx;
    endfunction

    // Requests at or above the token position win; otherwise wrap to the lowest set bit.
    assign w_req_hi = req & ~(r_ptr - N'(1));
    assign w_pick   = (|w_req_hi) ? (w_req_hi & (~w_req_hi + N'(1)))
                                  : (req & (~req + N'(1)));

    assign w_rel_normal = done[r_owner] | ~req[r_owner];
    assign w_rel_forced = ~w_rel_normal & (r_cnt == HOLD_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_grant_nxt   = r_grant;
        w_owner_nxt   = r_owner;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_GAP: begin
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
                if (|req) begin
                    w_grant_nxt = w_pick;
                    w_owner_nxt = onehot_idx(w_pick);
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_rel_normal || w_rel_forced) begin
                    w_grant_nxt   = '0;
                    w_ptr_nxt     = {r_grant[N-2:0], r_grant[N-1]};
                    w_timeout_nxt = w_rel_forced;
                    w_state_nxt   = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= N'(1);
            r_grant   <= '0;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_grant   <= w_grant_nxt;
            r_owner   <= w_owner_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign grant   = r_grant;
    assign owner   = r_owner;
    assign busy    = |r_grant;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Vector table plus scoreboard for ring_token_arbiter (N=4, MAX_HOLD=8),
// with hand-written sequences for asynchronous reset behaviour.
module tb_ring_token_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] grant;
        logic [1:0] owner;
        logic       busy;
        logic       tout;
        string      name;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];

    ring_token_arbiter #(.N(4), .MAX_HOLD(8), .CNT_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic add(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                       input logic [1:0] o, input logic b, input logic t, input string nm);
        vec_t v;
        v.req = r; v.done = d; v.grant = g; v.owner = o; v.busy = b; v.tout = t; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic compare(input logic [7:0] exp, input string nm);
        logic [7:0] act;
        act = {grant, owner, busy, timeout};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got grant/owner/busy/timeout=%b_%b_%b_%b want %b_%b_%b_%b",
                     nm, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] exp;
        req  = v.req;
        done = v.done;
        exp_q.push_back({v.grant, v.owner, v.busy, v.tout});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        compare(exp, v.name);
    endtask

    initial begin
        // Reset state, with all requests asserted.
        reset = 1'b1;
        req   = 4'b1111;
        done  = 4'b0000;
        #2;
        compare(8'b0000_00_0_0, "reset_t2");
        #5;
        compare(8'b0000_00_0_0, "reset_after_edge");
        reset = 1'b0;
        req   = 4'b0000;

        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "idle_no_req");
        add(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, "grant_req2");
        add(4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0, "done_req2_gap");
        add(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "idle_owner_held");
        // Round robin with all requesters; token sits at bit3 after owner 2.
        add(4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0, "rr_g3");
        add(4'b1111, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0, "rr_gap3");
        add(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "rr_g0");
        add(4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_gap0");
        add(4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, "rr_g1");
        add(4'b1111, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0, "rr_gap1");
        add(4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, "rr_g2");
        add(4'b1111, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0, "rr_gap2");
        add(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "rr_idle");
        // Non-owner done ignored; dropping the owner's req releases normally.
        add(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, "wrap_g1");
        add(4'b0010, 4'b1101, 4'b0010, 2'd1, 1'b1, 1'b0, "nonowner_done");
        add(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "req_drop_release");
        // Token at bit2: 1010 grants owner 3, then wraps to owner 1.
        add(4'b1010, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0, "ptr2_g3");
        add(4'b1010, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0, "ptr2_gap");
        add(4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, "ptr0_g1");
        add(4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0, "g1_release");
        add(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "idle2");
        // Hold limit: 8 cycles of grant, one timeout pulse, then regrant.
        add(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "hold_start");
        for (int i = 1; i <= 7; i++)
            add(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "hold_cycle");
        add(4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, "hold_timeout");
        add(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "regrant_pulse_end");
        for (int i = 1; i <= 7; i++)
            add(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "hold2_cycle");
        add(4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0, "done_at_limit");
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "idle3");
        // Token at bit1 after owner 0: req 0100 grants owner 2.
        add(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, "pre_reset_g2");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Asynchronous reset in the middle of a grant cycle.
        #2;
        reset = 1'b1;
        #1;
        compare(8'b0000_00_0_0, "async_reset_midgrant");
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b0110;
        @(posedge clk);
        #1;
        compare(8'b0010_01_1_0, "ptr_reset_to_bit0");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
